lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the MEM-stage request and the data-memory port.
- Accepts one load or store per handshake and formats store data into byte lanes with write strobes.
- Drives a request/grant/response memory handshake.
- For loads, registers the raw 32-bit word with its func3 and address[1:0], for the load-extension stage that follows.
- Asserts a stall while an access is outstanding.

Parameters:
ADDR_W, 32, byte-address width of req_addr and mem_addr
MAX_WAIT, 255, max cycles in WAIT before an error abort; counter width is clog2(MAX_WAIT+1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  MEM stage presents an access
req_ready  output  1  block can accept; high only in IDLE
req_we  input  1  1=store, 0=load
req_func3  input  3  RISC-V funct3 of the load/store
req_addr  input  ADDR_W  byte address from ALU
req_wdata  input  32  store source register value
mem_req  output  1  memory request, held until mem_gnt
mem_we  output  1  write enable accompanying mem_req
mem_addr  output  ADDR_W  word-aligned address (bits[1:0]=0)
mem_wstrb  output  4  byte write strobes
mem_wdata  output  32  lane-aligned store data
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word
ld_valid  output  1  one-cycle pulse: ld_* outputs hold a new load result
ld_data  output  32  raw loaded word, registered
ld_func3  output  3  func3 of the completed load
ld_addr01  output  2  req_addr[1:0] of the completed load
lsu_busy  output  1  pipeline stall; high whenever state != IDLE
lsu_err  output  1  one-cycle error pulse (timeout, or misalign when enabled)

Behaviour:
- Reset values: state IDLE; mem_req, mem_we, ld_valid, lsu_busy, lsu_err = 0; mem_addr, mem_wstrb, mem_wdata, ld_data, ld_func3, ld_addr01 = 0; wait counter = 0.
- Accept:
  - Occurs on req_valid & req_ready.
  - Captures mem_addr = {req_addr[ADDR_W-1:2],2'b00}, mem_we, mem_wstrb, mem_wdata, func3 and addr[1:0].
  - Enters REQ.
- Store formatting by func3:
  - SB (000): wstrb = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
  - SH (001): wstrb = addr[1] ? 1100 : 0011; wdata = halfword replicated x2.
  - SW (010): wstrb = 1111; wdata = req_wdata.
  - Any other func3: wstrb = 0000. The request is still issued.
- Loads: mem_wstrb = 0000, mem_wdata = 0.
- REQ:
  - mem_req = 1 with stable addr/we/wstrb/wdata until mem_gnt.
  - Store with gnt: go to IDLE. A new request can be accepted the following cycle.
  - Load with gnt: go to WAIT and clear the counter.
  - No gnt: stay in REQ (no timeout in REQ).
- WAIT:
  - On mem_rvalid: ld_data <= mem_rdata; ld_func3 and ld_addr01 <= captured values; ld_valid pulses the next cycle; go to IDLE.
  - Without rvalid: counter increments. When the counter reaches MAX_WAIT: pulse lsu_err, go to IDLE, ld_valid stays 0, ld_data unchanged.
- ld_* outputs hold their values until the next completed load.
- Latency: a load with gnt in its first REQ cycle and rvalid one cycle after gnt produces ld_valid 3 cycles after accept.
- mem_rvalid is ignored in IDLE and REQ. This covers a stray or late response, including one arriving after a timeout or a reset.
- mem_gnt is ignored outside REQ.
- Reset mid-operation:
  - mem_req drops immediately (asynchronous) and the outstanding access is abandoned.
  - No ld_valid is produced.
- lsu_busy is combinational from state. req_ready = (state == IDLE).

Optional Feature:
LSU_MISALIGN_CHK_EN
- Defined:
  - On accept, an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=00, is checked.
  - Such an access issues no memory request and stays in IDLE.
  - lsu_err pulses the next cycle; ld_valid stays 0.
- Undefined: no check. The access is issued with a word-aligned address and the low bits select lanes as above.

Test Plan:
- Store SB: addr 0x1003, wdata 0x000000A5, gnt in the first REQ cycle -> mem_addr 0x1000, wstrb 1000, wdata 0xA5A5A5A5, mem_req high exactly 1 cycle, busy 1 cycle.
- Load LH: addr 0x2002, gnt after 2 cycles, rvalid 3 cycles later with rdata 0xBEEF1234 -> ld_valid single pulse; ld_data 0xBEEF1234, ld_func3 001, ld_addr01 10; busy high throughout.
- Back-to-back: store SW then load LW, req_valid held -> second accept in the cycle after the store gnt; req_ready low during REQ/WAIT.
- Timeout: MAX_WAIT=4, load granted, no rvalid -> lsu_err pulses after 4 WAIT cycles; return to IDLE; a stray rvalid afterwards leaves ld_valid 0.
- Reset in WAIT: rst_n low for 1 cycle -> mem_req, busy, ld_valid 0 immediately; rvalid after reset is ignored.
- Misalign: LW at addr 0x3001 -> with LSU_MISALIGN_CHK_EN, no mem_req and lsu_err pulse; without it, mem_addr 0x3000 and a normal completion.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl_if
// Bundles every signal between the load/store sequencer and its surroundings.
//   - MEM-stage request:  req_valid/req_ready, req_we, req_func3, req_addr,
//                         req_wdata
//   - Data-memory port:   mem_req/mem_gnt, mem_we, mem_addr, mem_wstrb,
//                         mem_wdata, mem_rvalid, mem_rdata
//   - Load result:        ld_valid, ld_data, ld_func3, ld_addr01
//   - Status:             lsu_busy, lsu_err
// Modports:
//   slave  - the sequencer (lsu_mem_ctrl)
//   master - the environment: MEM stage, data memory and load-extension stage
// -----------------------------------------------------------------------------
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_func3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              ld_valid;
    logic [31:0]       ld_data;
    logic [2:0]        ld_func3;
    logic [1:0]        ld_addr01;

    logic              lsu_busy;
    logic              lsu_err;

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output ld_valid, ld_data, ld_func3, ld_addr01,
        output lsu_busy, lsu_err
    );

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  ld_valid, ld_data, ld_func3, ld_addr01,
        input  lsu_busy, lsu_err
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store sequencer between the MEM-stage request and the data-memory port.
// Accepts one access per req_valid/req_ready handshake, formats store data
// into byte lanes with strobes, runs a request/grant/response exchange with
// memory and registers the raw loaded word (with func3 and addr[1:0]) for the
// load-extension stage. lsu_busy stalls the pipeline while an access is open.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - lsu_mem_ctrl_if.slave (request, memory port, load result, status)
//
// Parameters:
//   ADDR_W   - byte-address width of req_addr / mem_addr
//   MAX_WAIT - WAIT cycles without a response before aborting with lsu_err
//
// Build option:
//   LSU_MISALIGN_CHK_EN - when defined, misaligned LH/LHU/SH and LW/SW are
//   refused at accept (no memory request, lsu_err pulse the next cycle).
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next, wait_cnt_inc;

    // Captured access
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [3:0]        wstrb_reg;
    logic [31:0]       wdata_reg;
    logic [2:0]        func3_reg;
    logic [1:0]        addr01_reg;

    // Load result and error pulse
    logic              ld_valid_reg;
    logic [31:0]       ld_data_reg;
    logic [2:0]        ld_func3_reg;
    logic [1:0]        ld_addr01_reg;
    logic              err_reg;

    logic              accept, capture, misalign, ld_done, err_set;
    logic [3:0]        sb_wstrb, fmt_wstrb;
    logic [31:0]       sb_wdata, sh_wdata, fmt_wdata;

    // Byte-lane views of the store source: SB replicates byte 0 into every
    // lane, SH replicates the low halfword into both halves.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign sb_wstrb[gi]        = (bus.req_addr[1:0] == 2'(gi));
        assign sb_wdata[8*gi +: 8] = bus.req_wdata[7:0];
        assign sh_wdata[8*gi +: 8] = bus.req_wdata[8*(gi%2) +: 8];
    end

    always_comb begin
        fmt_wstrb = 4'b0000;
        fmt_wdata = 32'h0;
        if (bus.req_we) begin
            case (bus.req_func3)
                3'b000: begin
                    fmt_wstrb = sb_wstrb;
                    fmt_wdata = sb_wdata;
                end
                3'b001: begin
                    fmt_wstrb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                    fmt_wdata = sh_wdata;
                end
                3'b010: begin
                    fmt_wstrb = 4'b1111;
                    fmt_wdata = bus.req_wdata;
                end
                // Unknown store width: request still goes out, no lanes written.
                default: begin
                    fmt_wstrb = 4'b0000;
                    fmt_wdata = 32'h0;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_CHK_EN
    logic is_half, is_word;
    // 101 is LHU for loads only; as a store it is an unknown width.
    assign is_half  = (bus.req_func3 == 3'b001) ||
                      (!bus.req_we && (bus.req_func3 == 3'b101));
    assign is_word  = (bus.req_func3 == 3'b010);
    assign misalign = (is_half && bus.req_addr[0]) ||
                      (is_word && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign accept       = bus.req_valid && (state_reg == S_IDLE);
    assign capture      = accept && !misalign;
    assign wait_cnt_inc = wait_cnt_reg + CNT_W'(1);

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        ld_done       = 1'b0;
        err_set       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (misalign) err_set    = 1'b1;
                    else          state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    if (we_reg) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = '0;
                    end
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    ld_done    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_inc;
                    if (wait_cnt_inc == CNT_W'(MAX_WAIT)) begin
                        err_set    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            wstrb_reg     <= 4'b0000;
            wdata_reg     <= 32'h0;
            func3_reg     <= 3'b000;
            addr01_reg    <= 2'b00;
            ld_valid_reg  <= 1'b0;
            ld_data_reg   <= 32'h0;
            ld_func3_reg  <= 3'b000;
            ld_addr01_reg <= 2'b00;
            err_reg       <= 1'b0;
        end else begin
            if (capture) begin
                addr_reg   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                we_reg     <= bus.req_we;
                wstrb_reg  <= fmt_wstrb;
                wdata_reg  <= fmt_wdata;
                func3_reg  <= bus.req_func3;
                addr01_reg <= bus.req_addr[1:0];
            end
            ld_valid_reg <= ld_done;
            err_reg      <= err_set;
            if (ld_done) begin
                ld_data_reg   <= bus.mem_rdata;
                ld_func3_reg  <= func3_reg;
                ld_addr01_reg <= addr01_reg;
            end
        end
    end

    // mem_req decodes straight from state so an asynchronous reset drops it
    // without waiting for a clock edge.
    assign bus.req_ready = (state_reg == S_IDLE);
    assign bus.lsu_busy  = (state_reg != S_IDLE);
    assign bus.mem_req   = (state_reg == S_REQ);
    assign bus.mem_we    = (state_reg == S_REQ) && we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wstrb = wstrb_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.ld_valid  = ld_valid_reg;
    assign bus.ld_data   = ld_data_reg;
    assign bus.ld_func3  = ld_func3_reg;
    assign bus.ld_addr01 = ld_addr01_reg;
    assign bus.lsu_err   = err_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Scoreboard bench for lsu_mem_ctrl (MAX_WAIT = 4). Expected memory requests
// and load results are queued when stimulus is driven and compared when the
// DUT presents a granted request or an ld_valid pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] wmask;
    } mem_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  func3;
        logic [1:0]  addr01;
    } ld_exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic ld_prev;

    mem_exp_t mem_q[$];
    ld_exp_t  ld_q[$];

    lsu_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_mem_ctrl #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mem_exp_t model(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wd);
        mem_exp_t m;
        m.we    = we;
        m.addr  = addr & 32'hFFFF_FFFC;
        m.wstrb = 4'b0000;
        m.wdata = 32'h0;
        m.wmask = 32'hFFFF_FFFF;
        if (we) begin
            case (f3)
                3'b000: begin
                    m.wstrb = 4'b0001 << addr[1:0];
                    m.wdata = wd[7:0] * 32'h0101_0101;
                end
                3'b001: begin
                    m.wstrb = addr[1] ? 4'b1100 : 4'b0011;
                    m.wdata = wd[15:0] * 32'h0001_0001;
                end
                3'b010: begin
                    m.wstrb = 4'b1111;
                    m.wdata = wd;
                end
                default: m.wmask = 32'h0;
            endcase
        end
        return m;
    endfunction

    // Present an access and hold it until accepted; expect_req queues the
    // memory request the DUT must later issue.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit expect_req);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_func3 = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 64) begin
            tick();
            n++;
        end
        check("issue_ready", {31'h0, bus.req_ready}, 32'h1);
        if (expect_req) mem_q.push_back(model(we, f3, addr, wd));
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic grant(input int delay);
        int n;
        n = 0;
        while (!bus.mem_req && n < 64) begin
            tick();
            n++;
        end
        repeat (delay) begin
            check("req_hold", {31'h0, bus.mem_req}, 32'h1);
            tick();
        end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
    endtask

    task automatic respond(input int delay, input logic [31:0] rd,
                           input logic [2:0] f3, input logic [1:0] a01);
        ld_exp_t e;
        repeat (delay) begin
            check("wait_busy", {31'h0, bus.lsu_busy}, 32'h1);
            tick();
        end
        e.data   = rd;
        e.func3  = f3;
        e.addr01 = a01;
        ld_q.push_back(e);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd;
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    // Monitor: compares granted requests and load results against the queues.
    always @(negedge clk) begin
        mem_exp_t me;
        ld_exp_t  le;
        if (rst_n) begin
            if (bus.mem_req && bus.mem_gnt) begin
                $display("mem txn we=%0d addr=%h wstrb=%b wdata=%h",
                         bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
                if (mem_q.size() == 0) begin
                    check("mem_unexpected", {31'h0, bus.mem_req}, 32'h0);
                end else begin
                    me = mem_q.pop_front();
                    check("mem_we", {31'h0, bus.mem_we}, {31'h0, me.we});
                    check("mem_addr", bus.mem_addr, me.addr);
                    check("mem_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, me.wstrb});
                    check("mem_wdata", bus.mem_wdata & me.wmask, me.wdata & me.wmask);
                end
            end
            if (bus.ld_valid) begin
                $display("load txn data=%h func3=%b addr01=%b",
                         bus.ld_data, bus.ld_func3, bus.ld_addr01);
                check("ld_single_pulse", {31'h0, ld_prev}, 32'h0);
                if (ld_q.size() == 0) begin
                    check("ld_unexpected", {31'h0, bus.ld_valid}, 32'h0);
                end else begin
                    le = ld_q.pop_front();
                    check("ld_data", bus.ld_data, le.data);
                    check("ld_func3", {29'h0, bus.ld_func3}, {29'h0, le.func3});
                    check("ld_addr01", {30'h0, bus.ld_addr01}, {30'h0, le.addr01});
                end
            end
            ld_prev <= bus.ld_valid;
        end else begin
            ld_prev <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [2:0]  f;
        checks   = 0;
        failures = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_func3  = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        repeat (2) tick();

        // Reset state
        check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("rst_busy", {31'h0, bus.lsu_busy}, 32'h0);
        check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rst_ld_valid", {31'h0, bus.ld_valid}, 32'h0);
        check("rst_err", {31'h0, bus.lsu_err}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_ld_data", bus.ld_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // Store SB at 0x1003, grant in first REQ cycle
        issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 1'b1);
        check("sb_mem_req", {31'h0, bus.mem_req}, 32'h1);
        check("sb_busy", {31'h0, bus.lsu_busy}, 32'h1);
        check("sb_addr", bus.mem_addr, 32'h0000_1000);
        check("sb_wstrb", {28'h0, bus.mem_wstrb}, 32'h8);
        check("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        grant(0);
        check("sb_req_one_cycle", {31'h0, bus.mem_req}, 32'h0);
        check("sb_busy_one_cycle", {31'h0, bus.lsu_busy}, 32'h0);

        // Load LH at 0x2002: grant after 2 cycles, rvalid 3 cycles after grant
        issue(1'b0, 3'b001, 32'h0000_2002, 32'h0, 1'b1);
        check("lh_addr", bus.mem_addr, 32'h0000_2000);
        check("lh_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
        check("lh_ready_req", {31'h0, bus.req_ready}, 32'h0);
        grant(2);
        check("lh_req_dropped", {31'h0, bus.mem_req}, 32'h0);
        respond(2, 32'hBEEF_1234, 3'b001, 2'b10);
        check("lh_ld_valid", {31'h0, bus.ld_valid}, 32'h1);
        check("lh_ld_data", bus.ld_data, 32'hBEEF_1234);
        check("lh_ld_func3", {29'h0, bus.ld_func3}, 32'h1);
        check("lh_ld_addr01", {30'h0, bus.ld_addr01}, 32'h2);
        tick();
        check("lh_ld_pulse_end", {31'h0, bus.ld_valid}, 32'h0);
        check("lh_ld_hold", bus.ld_data, 32'hBEEF_1234);

        // Minimum latency: ld_valid 3 cycles after accept
        issue(1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b1);
        grant(0);
        respond(0, 32'h0BAD_CAFE, 3'b010, 2'b00);
        check("lat_ld_valid", {31'h0, bus.ld_valid}, 32'h1);

        // Back-to-back: SW then LW with req_valid held
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_func3 = 3'b010;
        bus.req_addr  = 32'h0000_0100;
        bus.req_wdata = 32'h1122_3344;
        check("b2b_ready0", {31'h0, bus.req_ready}, 32'h1);
        mem_q.push_back(model(1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344));
        tick();
        check("b2b_ready_req", {31'h0, bus.req_ready}, 32'h0);
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0104;
        bus.mem_gnt   = 1'b1;
        tick();
        bus.mem_gnt   = 1'b0;
        check("b2b_ready_idle", {31'h0, bus.req_ready}, 32'h1);
        mem_q.push_back(model(1'b0, 3'b010, 32'h0000_0104, 32'h0));
        tick();
        bus.req_valid = 1'b0;
        check("b2b_second_busy", {31'h0, bus.lsu_busy}, 32'h1);
        grant(0);
        check("b2b_ready_wait", {31'h0, bus.req_ready}, 32'h0);
        respond(0, 32'h5555_AAAA, 3'b010, 2'b00);

        // Unknown store func3: request issued with no lanes enabled
        issue(1'b1, 3'b011, 32'h0000_0200, 32'hFFFF_FFFF, 1'b1);
        check("bad_f3_req", {31'h0, bus.mem_req}, 32'h1);
        grant(1);

        // Random stores and loads through the scoreboard
        for (int i = 0; i < 8; i++) begin
            f = 3'($urandom_range(0, 2));
            a = 32'h0000_5000 + 32'($urandom_range(0, 255));
            d = $urandom;
`ifdef LSU_MISALIGN_CHK_EN
            if (f == 3'b001) a[0] = 1'b0;
            if (f == 3'b010) a[1:0] = 2'b00;
`endif
            issue(1'b1, f, a, d, 1'b1);
            grant($urandom_range(0, 2));
        end
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: f = 3'b000;
                1: f = 3'b001;
                2: f = 3'b010;
                3: f = 3'b100;
                default: f = 3'b101;
            endcase
            a = 32'h0000_6000 + 32'($urandom_range(0, 255));
`ifdef LSU_MISALIGN_CHK_EN
            if (f[1:0] == 2'b01) a[0] = 1'b0;
            if (f == 3'b010) a[1:0] = 2'b00;
`endif
            issue(1'b0, f, a, 32'h0, 1'b1);
            grant($urandom_range(0, 2));
            respond($urandom_range(0, 2), $urandom, f, a[1:0]);
        end

        // Timeout: load granted, no response
        tick();
        d = bus.ld_data;
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 1'b1);
        grant(0);
        repeat (MAX_WAIT - 1) begin
            check("to_no_err_yet", {31'h0, bus.lsu_err}, 32'h0);
            check("to_busy", {31'h0, bus.lsu_busy}, 32'h1);
            tick();
        end
        tick();
        check("to_err_pulse", {31'h0, bus.lsu_err}, 32'h1);
        check("to_idle", {31'h0, bus.lsu_busy}, 32'h0);
        check("to_no_ld_valid", {31'h0, bus.ld_valid}, 32'h0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_0001;
        tick();
        bus.mem_rvalid = 1'b0;
        check("to_err_end", {31'h0, bus.lsu_err}, 32'h0);
        tick();
        check("to_stray_ld_valid", {31'h0, bus.ld_valid}, 32'h0);
        check("to_ld_data_hold", bus.ld_data, d);

        // Reset while in WAIT
        issue(1'b0, 3'b010, 32'h0000_0600, 32'h0, 1'b1);
        grant(0);
        check("rw_in_wait", {31'h0, bus.lsu_busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("rw_busy", {31'h0, bus.lsu_busy}, 32'h0);
        check("rw_ld_valid", {31'h0, bus.ld_valid}, 32'h0);
        tick();
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_0002;
        tick();
        bus.mem_rvalid = 1'b0;
        tick();
        check("rw_stray_ld_valid", {31'h0, bus.ld_valid}, 32'h0);
        check("rw_ld_data", bus.ld_data, 32'h0);
        check("rw_idle", {31'h0, bus.lsu_busy}, 32'h0);

        // Misaligned LW at 0x3001
`ifdef LSU_MISALIGN_CHK_EN
        issue(1'b0, 3'b010, 32'h0000_3001, 32'h0, 1'b0);
        check("mis_no_req", {31'h0, bus.mem_req}, 32'h0);
        check("mis_idle", {31'h0, bus.lsu_busy}, 32'h0);
        check("mis_err", {31'h0, bus.lsu_err}, 32'h1);
        tick();
        check("mis_err_end", {31'h0, bus.lsu_err}, 32'h0);
        check("mis_no_ld", {31'h0, bus.ld_valid}, 32'h0);
`else
        issue(1'b0, 3'b010, 32'h0000_3001, 32'h0, 1'b1);
        check("mis_addr", bus.mem_addr, 32'h0000_3000);
        grant(0);
        respond(0, 32'hCAFE_F00D, 3'b010, 2'b01);
        check("mis_ld_valid", {31'h0, bus.ld_valid}, 32'h1);
        check("mis_ld_addr01", {30'h0, bus.ld_addr01}, 32'h1);
`endif
        repeat (3) tick();

        check("mem_q_drained", mem_q.size(), 32'h0);
        check("ld_q_drained", ld_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
